// File: rtl/btb_pkg.sv
// Shared types and default geometry for the set-associative BTB.
// Imported by the BTB top level and its victim selector.
package btb_pkg;

  localparam int PC_BITS_DEF  = 32;
  localparam int SET_BITS_DEF = 4;
  localparam int TAG_BITS_DEF = 4;
  localparam int WAYS_DEF     = 2;

  typedef struct packed {
    logic                    valid;
    logic [TAG_BITS_DEF-1:0] tag;
    logic [PC_BITS_DEF-1:0]  target;
  } btb_entry_t;

  typedef enum logic {
    IDLE,
    FLUSH
  } btb_state_t;

  function automatic int way_bits(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/btb_victim_sel.sv
// Allocation way picker for one BTB set.
// Prefers the lowest invalid way, else the round-robin victim.
module btb_victim_sel #(
  parameter int WAYS     = 2,
  parameter int WAY_BITS = 1
) (
  input  logic [WAYS-1:0]     valid_i,
  input  logic [WAY_BITS-1:0] ptr_i,
  output logic [WAY_BITS-1:0] way_o,
  output logic                advance_o
);

  // Lowest free way wins; a full set evicts at the pointer
  always_comb begin
    advance_o = &valid_i;
    way_o     = ptr_i;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_i[w]) way_o = WAY_BITS'(w);
    end
  end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with registered lookup,
// resolution-time update and a one-set-per-cycle flush engine.
module btb_assoc
  import btb_pkg::*;
#(
  parameter int PC_BITS  = PC_BITS_DEF,
  parameter int SET_BITS = SET_BITS_DEF,
  parameter int TAG_BITS = TAG_BITS_DEF,
  parameter int WAYS     = WAYS_DEF,
  parameter int WAY_BITS = way_bits(WAYS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                lookupEn,
  input  logic [PC_BITS-1:0]  lookupPC,
  output logic                hit,
  output logic [PC_BITS-1:0]  predictedTarget,
  output logic [WAY_BITS-1:0] hitWay,
  input  logic                writeBTB,
  input  logic [PC_BITS-1:0]  oldPC,
  input  logic [PC_BITS-1:0]  resolvedTarget,
  input  logic                takenBranch,
  input  logic                flush,
  output logic                busy
);

  localparam int SETS = 1 << SET_BITS;
  localparam int TMSB = SET_BITS + TAG_BITS - 1;

  btb_state_t state_q, state_d;
  logic [SET_BITS-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d;

  logic [SETS-1:0][WAYS-1:0]     valid_q, valid_d;
  logic [SETS-1:0][WAY_BITS-1:0] victim_q, victim_d;
  logic [TAG_BITS-1:0] tag_q    [SETS][WAYS];
  logic [PC_BITS-1:0]  target_q [SETS][WAYS];

  logic                hit_q, hit_d;
  logic [PC_BITS-1:0]  tgt_q, tgt_d;
  logic [WAY_BITS-1:0] way_q, way_d;

  logic [SET_BITS-1:0] lk_set, up_set;
  logic [TAG_BITS-1:0] lk_tag, up_tag;

  logic [WAYS-1:0]     up_match;
  logic [WAY_BITS-1:0] match_way;
  logic [WAY_BITS-1:0] alloc_way;
  logic                alloc_adv;
  logic                wr_en;
  logic [WAY_BITS-1:0] wr_way;

  assign lk_set = lookupPC[SET_BITS-1:0];
  assign lk_tag = lookupPC[TMSB:SET_BITS];
  assign up_set = oldPC[SET_BITS-1:0];
  assign up_tag = oldPC[TMSB:SET_BITS];

  generate
    if (TMSB < PC_BITS - 1) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^{lookupPC[PC_BITS-1:TMSB+1],
                           oldPC[PC_BITS-1:TMSB+1]};
    end
  endgenerate

  // Tag compare for the fetch lookup; suppressed around flushes
  always_comb begin
    hit_d = 1'b0;
    tgt_d = '0;
    way_d = '0;
    if (lookupEn && state_q == IDLE && !flush) begin
      for (int w = WAYS - 1; w >= 0; w--) begin
        if (valid_q[lk_set][w] && tag_q[lk_set][w] == lk_tag) begin
          hit_d = 1'b1;
          tgt_d = target_q[lk_set][w];
          way_d = WAY_BITS'(w);
        end
      end
    end
  end

  // Tag compare for the resolving branch's set
  always_comb begin
    up_match  = '0;
    match_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      up_match[w] = valid_q[up_set][w] && tag_q[up_set][w] == up_tag;
      if (up_match[w]) match_way = WAY_BITS'(w);
    end
  end

  btb_victim_sel #(
    .WAYS     (WAYS),
    .WAY_BITS (WAY_BITS)
  ) u_victim (
    .valid_i   (valid_q[up_set]),
    .ptr_i     (victim_q[up_set]),
    .way_o     (alloc_way),
    .advance_o (alloc_adv)
  );

  // Update, allocation and flush sequencing
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    victim_d = victim_q;
    wr_en    = 1'b0;
    wr_way   = alloc_way;
    unique case (state_q)
      IDLE: begin
        if (writeBTB) begin
          if (|up_match) begin
            if (takenBranch) begin
              wr_en  = 1'b1;
              wr_way = match_way;
            end else begin
              valid_d[up_set][match_way] = 1'b0;
            end
          end else if (takenBranch) begin
            wr_en = 1'b1;
            valid_d[up_set][alloc_way] = 1'b1;
            if (alloc_adv) begin
              victim_d[up_set] =
                (victim_q[up_set] == WAY_BITS'(WAYS - 1)) ?
                '0 : victim_q[up_set] + 1'b1;
            end
          end
        end
        if (flush) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
      end
      FLUSH: begin
        valid_d[cnt_q]  = '0;
        victim_d[cnt_q] = '0;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SET_BITS'(SETS - 1)) state_d = IDLE;
      end
    endcase
    busy_d = (state_d == FLUSH);
  end

  // Control state, valid bits and lookup result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= '0;
      victim_q <= '0;
      hit_q    <= 1'b0;
      tgt_q    <= '0;
      way_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      victim_q <= victim_d;
      hit_q    <= hit_d;
      tgt_q    <= tgt_d;
      way_q    <= way_d;
    end
  end

  // Tag and target storage; validity lives in valid_q
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[up_set][wr_way]    <= up_tag;
      target_q[up_set][wr_way] <= resolvedTarget;
    end
  end

  assign hit             = hit_q;
  assign predictedTarget = tgt_q;
  assign hitWay          = way_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc with default geometry
// (16 sets, 4-bit tag, 2 ways).
module tb_btb_assoc;

  logic        clk = 1'b0;
  logic        reset;
  logic        lookupEn;
  logic [31:0] lookupPC;
  logic        hit;
  logic [31:0] predictedTarget;
  logic [0:0]  hitWay;
  logic        writeBTB;
  logic [31:0] oldPC;
  logic [31:0] resolvedTarget;
  logic        takenBranch;
  logic        flush;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int busy_cycles;

  btb_assoc dut (
    .clk             (clk),
    .reset           (reset),
    .lookupEn        (lookupEn),
    .lookupPC        (lookupPC),
    .hit             (hit),
    .predictedTarget (predictedTarget),
    .hitWay          (hitWay),
    .writeBTB        (writeBTB),
    .oldPC           (oldPC),
    .resolvedTarget  (resolvedTarget),
    .takenBranch     (takenBranch),
    .flush           (flush),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt,
                     input logic tk);
    writeBTB = 1'b1;
    oldPC = pc;
    resolvedTarget = tgt;
    takenBranch = tk;
    step();
    writeBTB = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    lookupEn = 1'b1;
    lookupPC = pc;
    step();
    lookupEn = 1'b0;
  endtask

  task automatic look_hit(input string tag, input logic [31:0] pc,
                          input logic [31:0] tgt, input logic w);
    look(pc);
    chk({tag, ".hit"}, 32'(hit), 32'd1);
    chk({tag, ".tgt"}, predictedTarget, tgt);
    chk({tag, ".way"}, 32'(hitWay), 32'(w));
  endtask

  task automatic look_miss(input string tag, input logic [31:0] pc);
    look(pc);
    chk({tag, ".hit"}, 32'(hit), 32'd0);
    chk({tag, ".tgt"}, predictedTarget, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    lookupEn = 1'b0;
    lookupPC = '0;
    writeBTB = 1'b0;
    oldPC = '0;
    resolvedTarget = '0;
    takenBranch = 1'b0;
    flush = 1'b0;
    step();
    step();
    reset = 1'b0;

    // 1: reset state
    chk("rst.busy", 32'(busy), 32'd0);
    look_miss("t1", 32'h10);
    chk("t1.way", 32'(hitWay), 32'd0);

    // 2: first allocation goes to way 0
    upd(32'h23, 32'h80, 1'b1);
    look_hit("t2a", 32'h23, 32'h80, 1'b0);
    look_miss("t2b", 32'h33);

    // 3: overwrite, fill way 1, evict way 0
    upd(32'h23, 32'h80, 1'b1);
    upd(32'h33, 32'h90, 1'b1);
    upd(32'h43, 32'hA0, 1'b1);
    look_miss("t3a", 32'h23);
    look_hit("t3b", 32'h33, 32'h90, 1'b1);
    look_hit("t3c", 32'h43, 32'hA0, 1'b0);

    // 4: not-taken invalidates; refill without eviction
    upd(32'h33, 32'h0, 1'b0);
    look_miss("t4a", 32'h33);
    upd(32'h53, 32'hB0, 1'b1);
    look_hit("t4b", 32'h43, 32'hA0, 1'b0);
    look_hit("t4c", 32'h53, 32'hB0, 1'b1);
    // victim pointer is now 1: next eviction hits way 1
    upd(32'h63, 32'hC0, 1'b1);
    look_hit("t4d", 32'h43, 32'hA0, 1'b0);
    look_miss("t4e", 32'h53);
    look_hit("t4f", 32'h63, 32'hC0, 1'b1);

    // 5: fill, then flush
    for (int i = 1; i < 16; i++) upd(32'(i), 32'h100 + 32'(i), 1'b1);
    look_hit("t5pre", 32'h05, 32'h105, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    busy_cycles = 0;
    while (busy && busy_cycles < 40) begin
      busy_cycles++;
      lookupEn = 1'b1;
      lookupPC = 32'h01;
      writeBTB = (busy_cycles == 10);
      oldPC = 32'h05;
      resolvedTarget = 32'h555;
      takenBranch = 1'b1;
      flush = (busy_cycles == 3);
      step();
      chk("t5.hit_busy", 32'(hit), 32'd0);
    end
    lookupEn = 1'b0;
    writeBTB = 1'b0;
    flush = 1'b0;
    chk("t5.busy_cycles", 32'(busy_cycles), 32'd16);
    for (int i = 1; i < 16; i++) begin
      look(32'(i));
      chk("t5.post_miss", 32'(hit), 32'd0);
    end
    look_miss("t5.x43", 32'h43);
    look_miss("t5.x63", 32'h63);

    // 6: reset in the middle of a flush
    upd(32'h07, 32'h700, 1'b1);
    upd(32'h0E, 32'hE00, 1'b1);
    look_hit("t6pre", 32'h0E, 32'hE00, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("t6.busy_mid", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6.busy_rst", 32'(busy), 32'd0);
    chk("t6.hit_rst", 32'(hit), 32'd0);
    step();
    reset = 1'b0;
    look_miss("t6a", 32'h07);
    look_miss("t6b", 32'h0E);
    chk("t6.busy_after", 32'(busy), 32'd0);

    // 7: same-edge lookup and update read old contents
    lookupEn = 1'b1;
    lookupPC = 32'h27;
    writeBTB = 1'b1;
    oldPC = 32'h27;
    resolvedTarget = 32'h270;
    takenBranch = 1'b1;
    step();
    lookupEn = 1'b0;
    writeBTB = 1'b0;
    chk("t7.same_edge", 32'(hit), 32'd0);
    look_hit("t7b", 32'h27, 32'h270, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/btb_assoc.md
Name: btb_assoc

Overview:
Parametrised set-associative branch target buffer for the fetch stage. It predicts the next fetch PC for taken branches and jumps. Lookup is synchronous on posedge clk with one-cycle latency. Updates come from the branch ALU at resolution, with allocation, round-robin replacement and invalidate-on-not-taken. A multi-cycle flush FSM clears all entries after a pipeline-wide recovery.

Parameters:
PC_BITS, 32, width of PC and target addresses
SET_BITS, 4, log2 number of sets; set index = pc[SET_BITS-1:0]
TAG_BITS, 4, tag = pc[SET_BITS+TAG_BITS-1:SET_BITS]; SET_BITS+TAG_BITS <= PC_BITS
WAYS, 2, associativity; power of two, 1..8
WAY_BITS, max(1,$clog2(WAYS)), derived, width of way indices

Ports:
clk  in  1  single clock, all state on posedge
reset  in  1  asynchronous, active-high reset
lookupEn  in  1  request a prediction for lookupPC this cycle
lookupPC  in  PC_BITS  fetch PC to predict from
hit  out  1  registered; valid tagged entry found for the previous cycle's lookup
predictedTarget  out  PC_BITS  target of the hitting way; 0 when hit=0
hitWay  out  WAY_BITS  index of the hitting way; 0 when hit=0
writeBTB  in  1  resolved-branch update strobe
oldPC  in  PC_BITS  PC of the resolved branch/jump
resolvedTarget  in  PC_BITS  resolved target address
takenBranch  in  1  1 = taken branch or jump, 0 = not taken
flush  in  1  one-cycle pulse that starts a full invalidate
busy  out  1  high while a flush is in progress

Behaviour:
- Reset (async): all valid bits 0, victim pointers 0, FSM IDLE, hit/predictedTarget/hitWay/busy = 0. Target and tag arrays are not reset.
- Lookup: a lookup at edge N yields hit/predictedTarget/hitWay after edge N, held for one cycle. If lookupEn=0, hit=0 after the next edge.
- Hit condition: any way with valid=1 and stored tag == lookup tag. Allocation guarantees at most one matching way.
- Update with writeBTB=1, FSM IDLE, oldPC set s, tag t:
  - Matching valid way, taken=1: overwrite target; replacement state unchanged.
  - Matching valid way, taken=0: clear that way's valid bit.
  - No match, taken=1: allocate the lowest-index invalid way. If every way is valid, evict the way at victimPtr[s] and advance victimPtr[s] modulo WAYS. Write tag, target and valid=1.
  - No match, taken=0: no change.
- Read-before-write: a lookup and an update to the same set at the same edge return the pre-update contents. No bypass.
- Flush FSM:
  - IDLE -> FLUSH on flush=1. The set counter loads 0 and busy=1 from the next cycle.
  - Each FLUSH cycle clears the valid bits of all ways in set[counter] and resets victimPtr[counter] to 0, then increments the counter.
  - After set 2^SET_BITS-1, go to IDLE; busy=0 on the next cycle.
  - Total busy time is 2^SET_BITS cycles.
  - During FLUSH: hit is forced to 0, writeBTB is ignored, and flush pulses are ignored.
- Reset asserted mid-flush: immediate return to IDLE with busy=0 and all entries invalid.
- Widths: tag and index are pure bit slices, with no arithmetic on PCs. victimPtr wraps WAYS-1 -> 0.

Decomposition:
- Package btb_pkg:
  - btb_entry_t struct {valid, tag[TAG_BITS], target[PC_BITS]}
  - btb_state_t enum {IDLE, FLUSH}
  - SET_BITS/TAG_BITS/WAYS defaults as localparams
- Sub-module btb_victim_sel (combinational): takes the per-set valid vector and victimPtr; returns the allocation way and a pointer-advance flag.
- Top level holds the arrays, lookup registers and FSM.

Test Plan:
1. Reset, then lookup 0x10 -> next cycle hit=0, predictedTarget=0, busy=0.
2. Update oldPC=0x23, taken=1, target=0x80; then lookup 0x23 -> hit=1, predictedTarget=0x80, hitWay=0. Lookup 0x33 (same set, different tag) -> hit=0.
3. Taken updates to 0x23 (target 0x80), 0x33 (target 0x90), 0x43 (target 0xA0) -> 0x43 evicts way 0. Lookups: 0x23 miss; 0x33 hit way 1 target 0x90; 0x43 hit way 0 target 0xA0.
4. Not-taken update 0x33 -> lookup 0x33 misses. Taken update 0x53 target 0xB0 fills way 1 with no eviction; 0x43 still hits.
5. Fill 0x01..0x0F (all taken), then pulse flush:
   - busy high exactly 16 cycles.
   - hit=0 throughout; a writeBTB to 0x05 during the flush is dropped.
   - After the flush, every prior PC misses.
6. Reset asserted at flush cycle 5 -> busy=0 immediately, all lookups miss.
7. Update 0x27 taken and lookup 0x27 at the same edge -> miss; the next-cycle lookup of 0x27 hits.
